// File: rtl/audio_axis_pkg.sv
// rtl/audio_axis_pkg.sv - shared types and helpers for the audio AXI-Stream gain path
package audio_axis_pkg;
    typedef enum logic [1:0] {HOLD, UP, DOWN} ramp_state_t;

    function automatic int unsigned unity_code(input int unsigned gain_width);
        return 32'd1 << (gain_width - 1);
    endfunction

    // Clamp a sign-extended value into the two's complement range of a width-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) return max_v;
        if (value < min_v) return min_v;
        return value;
    endfunction
endpackage

// File: rtl/gain_ramp.sv
// rtl/gain_ramp.sv - synchronised gain/mute target and per-frame gain ramp
module gain_ramp import audio_axis_pkg::*; #(
    parameter int GAIN_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GAIN_WIDTH-1:0] sw,
    input  logic                  mute,
    input  logic                  boundary,
    output logic [GAIN_WIDTH-1:0] cur_gain,
    output ramp_state_t           state
);
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_code(GAIN_WIDTH));
    localparam logic [GAIN_WIDTH-1:0] ONE   = GAIN_WIDTH'(1);

    logic [GAIN_WIDTH-1:0]  sw_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] mute_sync;
    logic [GAIN_WIDTH-1:0]  target;
    logic [GAIN_WIDTH-1:0]  step_up;
    logic [GAIN_WIDTH-1:0]  step_dn;

    assign target  = mute_sync[SYNC_STAGES-1] ? '0 : sw_sync[SYNC_STAGES-1];
    assign step_up = cur_gain + ONE;
    assign step_dn = cur_gain - ONE;

    // Direction is decided from this cycle's target, so a redirect takes effect at the very next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
            mute_sync <= '0;
            cur_gain  <= UNITY;
            state     <= HOLD;
        end else begin
            sw_sync[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
            mute_sync <= {mute_sync[SYNC_STAGES-2:0], mute};
            if (boundary) begin
                if (cur_gain < target) begin
                    cur_gain <= step_up;
                    state    <= (step_up == target) ? HOLD : UP;
                end else if (cur_gain > target) begin
                    cur_gain <= step_dn;
                    state    <= (step_dn == target) ? HOLD : DOWN;
                end else begin
                    state <= HOLD;
                end
            end
        end
    end
endmodule

// File: rtl/axis_multichannel_gain_ramp.sv
// rtl/axis_multichannel_gain_ramp.sv - multichannel AXI-Stream gain stage with ramp, mute and saturation
module axis_multichannel_gain_ramp import audio_axis_pkg::*; #(
    parameter int DATA_WIDTH   = 24,
    parameter int NUM_CHANNELS = 2,
    parameter int GAIN_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic [GAIN_WIDTH-1:0] sw,
    input  logic                  mute,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  frame_err,
    output logic [GAIN_WIDTH-1:0] cur_gain
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

    logic                   en;
    logic                   accept;
    logic                   last_ch;
    logic                   boundary;
    logic [CW-1:0]          ch;
    logic signed [PW-1:0]   data_ext;
    logic signed [PW-1:0]   gain_ext;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   res;
    logic [DATA_WIDTH-1:0]  sat_data;
    logic                   s1_valid;
    logic                   s1_last;
    logic signed [PW-1:0]   s1_prod;
    ramp_state_t            unused_ramp_state;

    assign en           = !m_axis_valid || m_axis_ready;
    assign s_axis_ready = en;
    assign accept       = s_axis_valid && en;
    assign last_ch      = (ch == LAST_CH);
    assign boundary     = accept && (s_axis_last || last_ch);

    // Gain is zero-extended so the top code still multiplies as a positive factor.
    assign data_ext = {{(GAIN_WIDTH+1){s_axis_data[DATA_WIDTH-1]}}, s_axis_data};
    assign gain_ext = {{(DATA_WIDTH+1){1'b0}}, cur_gain};
    assign prod     = data_ext * gain_ext;
    assign res      = s1_prod >>> (GAIN_WIDTH - 1);
    assign sat_data = DATA_WIDTH'(sat_signed({{(64-PW){res[PW-1]}}, res}, DATA_WIDTH));

    gain_ramp #(
        .GAIN_WIDTH  (GAIN_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_gain_ramp (
        .clk      (axis_clk),
        .rst_n    (axis_resetn),
        .sw       (sw),
        .mute     (mute),
        .boundary (boundary),
        .cur_gain (cur_gain),
        .state    (unused_ramp_state)
    );

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s1_prod      <= '0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            ch           <= '0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= accept && (s_axis_last != last_ch);
            if (accept) ch <= boundary ? '0 : ch + CW'(1);
            if (en) begin
                s1_valid     <= s_axis_valid;
                m_axis_valid <= s1_valid;
                if (accept) begin
                    s1_prod <= prod;
                    s1_last <= s_axis_last;
                end
                if (s1_valid) begin
                    m_axis_data <= sat_data;
                    m_axis_last <= s1_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_multichannel_gain_ramp.sv
// tb/tb_axis_multichannel_gain_ramp.sv - self-checking bench for axis_multichannel_gain_ramp
module tb_axis_multichannel_gain_ramp;
    localparam int DW = 24;
    localparam int NC = 2;
    localparam int GW = 4;
    localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint MINV = -MAXV - 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } sb_t;

    typedef struct {
        logic [DW-1:0] din;
        logic          lin;
        logic [DW-1:0] dexp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [GW-1:0] sw;
    logic          mute;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic          s_axis_last;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          m_axis_last;
    logic          frame_err;
    logic [GW-1:0] cur_gain;

    int            n_vec = 0;
    int            n_err = 0;
    sb_t           sb_q[$];
    int            m_gain, m_target, m_ch;
    bit            rand_ready = 0;
    bit            use_tbl = 0;
    logic [DW-1:0] tbl_exp;
    vec_t          tbl8[6];
    vec_t          tbl15[6];
    int            ramp_exp[4];

    always #5 clk = ~clk;

    axis_multichannel_gain_ramp dut (
        .axis_clk     (clk),
        .axis_resetn  (rst_n),
        .sw           (sw),
        .mute         (mute),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .frame_err    (frame_err),
        .cur_gain     (cur_gain)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden model: gain used is the one in force when the beat is accepted; step at frame boundaries.
    task automatic model_accept(input logic [DW-1:0] d, input logic l, output logic err);
        longint p;
        sb_t    e;
        logic   lastch;
        p = longint'($signed(d)) * longint'(m_gain);
        p = p >>> (GW - 1);
        if (p > MAXV) p = MAXV;
        else if (p < MINV) p = MINV;
        e.data = use_tbl ? tbl_exp : DW'(p);
        e.last = l;
        sb_q.push_back(e);
        lastch = (m_ch == NC - 1);
        err = (l != lastch);
        if (l || lastch) begin
            m_ch = 0;
            if (m_gain < m_target) m_gain++;
            else if (m_gain > m_target) m_gain--;
        end else begin
            m_ch++;
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, output logic acc);
        logic mr;
        logic fire_in;
        logic exp_err;
        sb_t  e;
        mr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_valid = v;
        s_axis_data  = d;
        s_axis_last  = l;
        m_axis_ready = mr;
        #1;
        if (m_axis_valid && m_axis_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got 0x%0h expected none", m_axis_data);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", m_axis_data, e.data);
                chk("out_last", m_axis_last, e.last);
            end
        end
        fire_in = v && s_axis_ready;
        exp_err = 1'b0;
        if (fire_in) model_accept(d, l, exp_err);
        @(posedge clk);
        @(negedge clk);
        chk("frame_err", frame_err, exp_err);
        if (fire_in) chk("cur_gain", cur_gain, m_gain);
        acc = fire_in;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            step(1'b1, d, l, acc);
            n++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no handshake expected one within 64 cycles");
        end
    endtask

    task automatic send_exp(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] e);
        use_tbl = 1;
        tbl_exp = e;
        send(d, l);
        use_tbl = 0;
    endtask

    task automatic frame(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        send(d0, 1'b0);
        send(d1, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc);
    endtask

    initial begin
        tbl8[0]  = '{24'h100000, 1'b0, 24'h100000};
        tbl8[1]  = '{24'hF00000, 1'b1, 24'hF00000};
        tbl8[2]  = '{24'h7FFFFF, 1'b0, 24'h7FFFFF};
        tbl8[3]  = '{24'h800000, 1'b1, 24'h800000};
        tbl8[4]  = '{24'hFFFFFF, 1'b0, 24'hFFFFFF};
        tbl8[5]  = '{24'h000001, 1'b1, 24'h000001};
        tbl15[0] = '{24'h7FFFFF, 1'b0, 24'h7FFFFF};
        tbl15[1] = '{24'h800000, 1'b1, 24'h800000};
        tbl15[2] = '{24'h100000, 1'b0, 24'h1E0000};
        tbl15[3] = '{24'hFFFFF8, 1'b1, 24'hFFFFF1};
        tbl15[4] = '{24'h000008, 1'b0, 24'h00000F};
        tbl15[5] = '{24'hFFFFFF, 1'b1, 24'hFFFFFE};
        ramp_exp = '{9, 10, 11, 12};

        rst_n = 1'b0;
        sw = 4'd8;
        mute = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data = '0;
        s_axis_last = 1'b0;
        m_axis_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_axis_valid, 0);
        chk("rst_m_data", m_axis_data, 0);
        chk("rst_m_last", m_axis_last, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_cur_gain", cur_gain, 8);
        chk("rst_s_ready", s_axis_ready, 1);
        rst_n = 1'b1;
        m_gain = 8;
        m_target = 8;
        m_ch = 0;
        idle(5);

        // Unity gain: two-cycle latency, then table of pass-through samples.
        send(24'h100000, 1'b0);
        chk("lat_valid_c1", m_axis_valid, 0);
        idle(1);
        chk("lat_valid_c2", m_axis_valid, 1);
        send(24'hF00000, 1'b1);
        for (int i = 0; i < 6; i++) send_exp(tbl8[i].din, tbl8[i].lin, tbl8[i].dexp);
        idle(3);

        // Ramp 8 -> 12, one code per frame.
        sw = 4'd12;
        m_target = 12;
        idle(4);
        for (int k = 0; k < 4; k++) begin
            frame(24'h100000, 24'hF00000);
            chk("ramp_up_gain", cur_gain, ramp_exp[k]);
        end
        send_exp(24'h100000, 1'b0, 24'h180000);
        send_exp(24'hF00000, 1'b1, 24'hE80000);

        // Max gain with saturation on both rails and floor rounding.
        sw = 4'd15;
        m_target = 15;
        idle(4);
        repeat (3) frame(24'h000100, 24'hFFFF00);
        chk("gain_15", cur_gain, 15);
        for (int i = 0; i < 6; i++) send_exp(tbl15[i].din, tbl15[i].lin, tbl15[i].dexp);

        // Back to unity, then mute ramp down and release ramp up.
        sw = 4'd8;
        m_target = 8;
        idle(4);
        repeat (7) frame(24'h012345, 24'hFEDCBA);
        chk("back_to_unity", cur_gain, 8);
        mute = 1'b1;
        m_target = 0;
        idle(4);
        repeat (8) frame(24'h100000, 24'hF00000);
        chk("muted_gain", cur_gain, 0);
        send_exp(24'h100000, 1'b0, 24'h000000);
        send_exp(24'h7FFFFF, 1'b1, 24'h000000);
        mute = 1'b0;
        m_target = 8;
        idle(4);
        repeat (8) frame(24'h100000, 24'hF00000);
        chk("unmuted_gain", cur_gain, 8);

        // Random backpressure over 1000 samples with a ramp in progress.
        sw = 4'd13;
        m_target = 13;
        idle(4);
        rand_ready = 1;
        repeat (500) frame(DW'($urandom()), DW'($urandom()));
        rand_ready = 0;
        idle(4);
        chk("sb_empty_random", sb_q.size(), 0);

        // Frame alignment errors and resync.
        sw = 4'd10;
        m_target = 10;
        idle(4);
        repeat (5) frame(24'h000010, 24'hFFFFF0);
        chk("gain_10", cur_gain, 10);
        send(24'h111111, 1'b1);
        chk("ferr_early_last", frame_err, 1);
        idle(1);
        chk("ferr_one_cycle", frame_err, 0);
        frame(24'h222222, 24'h333333);
        send(24'h444444, 1'b0);
        send(24'h555555, 1'b0);
        chk("ferr_missing_last", frame_err, 1);
        frame(24'h666666, 24'h777777);

        // Asynchronous reset mid-frame drops in-flight samples.
        send(24'h100000, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_axis_valid, 0);
        chk("midrst_cur_gain", cur_gain, 8);
        chk("midrst_m_data", m_axis_data, 0);
        sb_q.delete();
        m_ch = 0;
        m_gain = 8;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        frame(24'h100000, 24'hF00000);
        idle(4);
        chk("sb_empty_final", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
